// File: rtl/marker_pkg.sv
// Shared types for the marker run detector: colour codes, FSM states, run events and the length qualifier.
package marker_pkg;

  // Event field width; must equal the X_WIDTH the detector is built with.
  localparam int unsigned EV_X_WIDTH = 11;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OUT1,
    S_INN
  } state_t;

  typedef struct packed {
    logic                  valid;
    colour_t               colour;
    logic [EV_X_WIDTH-1:0] len;
    logic [EV_X_WIDTH-1:0] start;
  } run_event_t;

  function automatic logic qual(input logic [EV_X_WIDTH-1:0] len,
                                input int unsigned min_run,
                                input int unsigned max_run);
    return (32'(len) >= min_run) && (32'(len) <= max_run);
  endfunction

endpackage

// File: rtl/marker_run_detect_if.sv
// Pixel stream in, marker report out; master drives pixels, slave is the detector.
interface marker_run_detect_if
  import marker_pkg::*;
#(
  parameter int unsigned X_WIDTH = 11
);
  logic               pixel_valid_in;
  colour_t            pixel_in;
  logic               line_start_in;
  logic               line_end_in;
  logic               marker_found_out;
  logic [X_WIDTH-1:0] marker_x_out;
  logic [X_WIDTH+1:0] marker_width_out;

  modport master (
    output pixel_valid_in, pixel_in, line_start_in, line_end_in,
    input  marker_found_out, marker_x_out, marker_width_out
  );

  modport slave (
    input  pixel_valid_in, pixel_in, line_start_in, line_end_in,
    output marker_found_out, marker_x_out, marker_width_out
  );
endinterface

// File: rtl/run_tracker.sv
// Run-length tracker: x counter, optional glitch filter, and one run event per closed run.
// ev_now is combinational from the accepted pixel; ev_pend carries a second closure into the next cycle.
module run_tracker
  import marker_pkg::*;
#(
  parameter int unsigned X_WIDTH = 11,
  parameter int unsigned MAX_RUN = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       pix_vld,
  input  colour_t    pix,
  input  logic       line_start,
  input  logic       line_end,
  output run_event_t ev_now,
  output run_event_t ev_pend,
  output logic       line_restart
);
  typedef logic [X_WIDTH-1:0] xw_t;
  localparam xw_t LEN_SAT = xw_t'(MAX_RUN + 1);

  xw_t        x_q, x_d, px;
  colour_t    run_colour_q, run_colour_d;
  xw_t        run_len_q, run_len_d;
  xw_t        run_start_q, run_start_d;
  logic       run_open_q, run_open_d;
  run_event_t pend_q, pend_d;
`ifdef GLITCH_FILTER_EN
  logic       cand_vld_q, cand_vld_d;
  colour_t    cand_colour_q, cand_colour_d;
  xw_t        cand_x_q, cand_x_d;
  xw_t        merged_len;
`endif

  function automatic xw_t bump(input xw_t len);
    return (len >= LEN_SAT) ? LEN_SAT : len + xw_t'(1);
  endfunction

  function automatic run_event_t mk_ev(input colour_t c, input xw_t len, input xw_t start);
    run_event_t e;
    e.valid  = 1'b1;
    e.colour = c;
    e.len    = EV_X_WIDTH'(len);
    e.start  = EV_X_WIDTH'(start);
    return e;
  endfunction

  always_comb begin
    x_d          = x_q;
    run_colour_d = run_colour_q;
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    run_open_d   = run_open_q;
    pend_d       = '0;
    ev_now       = '0;
    line_restart = 1'b0;
    px           = line_start ? '0 : x_q;
`ifdef GLITCH_FILTER_EN
    cand_vld_d    = cand_vld_q;
    cand_colour_d = cand_colour_q;
    cand_x_d      = cand_x_q;
    merged_len    = run_len_q;
`endif
    if (pix_vld) begin
      x_d = px + xw_t'(1);
      if (line_start || !run_open_q) begin
        line_restart = line_start;
        run_open_d   = 1'b1;
        run_colour_d = pix;
        run_len_d    = xw_t'(1);
        run_start_d  = px;
`ifdef GLITCH_FILTER_EN
        cand_vld_d   = 1'b0;
`endif
      end else begin
`ifdef GLITCH_FILTER_EN
        if (cand_vld_q && pix == cand_colour_q) begin
          // Candidate confirmed: the new run started at the candidate pixel.
          ev_now       = mk_ev(run_colour_q, run_len_q, run_start_q);
          run_colour_d = cand_colour_q;
          run_len_d    = xw_t'(2);
          run_start_d  = cand_x_q;
          cand_vld_d   = 1'b0;
        end else begin
          merged_len = cand_vld_q ? bump(run_len_q) : run_len_q;
          cand_vld_d = 1'b0;
          if (pix == run_colour_q) begin
            run_len_d = bump(merged_len);
          end else begin
            run_len_d     = merged_len;
            cand_vld_d    = 1'b1;
            cand_colour_d = pix;
            cand_x_d      = px;
          end
        end
`else
        if (pix != run_colour_q) begin
          ev_now       = mk_ev(run_colour_q, run_len_q, run_start_q);
          run_colour_d = pix;
          run_len_d    = xw_t'(1);
          run_start_d  = px;
        end else begin
          run_len_d = bump(run_len_q);
        end
`endif
      end
      if (line_end) begin
        run_open_d = 1'b0;
`ifdef GLITCH_FILTER_EN
        if (cand_vld_d) begin
          ev_now     = mk_ev(run_colour_d, run_len_d, run_start_d);
          pend_d     = mk_ev(cand_colour_d, xw_t'(1), cand_x_d);
          cand_vld_d = 1'b0;
        end else
`endif
        if (ev_now.valid) pend_d = mk_ev(run_colour_d, run_len_d, run_start_d);
        else              ev_now = mk_ev(run_colour_d, run_len_d, run_start_d);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_q           <= '0;
      run_colour_q  <= '0;
      run_len_q     <= '0;
      run_start_q   <= '0;
      run_open_q    <= 1'b0;
      pend_q        <= '0;
`ifdef GLITCH_FILTER_EN
      cand_vld_q    <= 1'b0;
      cand_colour_q <= '0;
      cand_x_q      <= '0;
`endif
    end else begin
      x_q           <= x_d;
      run_colour_q  <= run_colour_d;
      run_len_q     <= run_len_d;
      run_start_q   <= run_start_d;
      run_open_q    <= run_open_d;
      pend_q        <= pend_d;
`ifdef GLITCH_FILTER_EN
      cand_vld_q    <= cand_vld_d;
      cand_colour_q <= cand_colour_d;
      cand_x_q      <= cand_x_d;
`endif
    end
  end

  assign ev_pend = pend_q;

endmodule

// File: rtl/marker_run_detect.sv
// OUTER-INNER-OUTER marker detector over run-length events; pulse 1 clock after the closing pixel.
// Define GLITCH_FILTER_EN to reject single-pixel colour changes (adds one valid pixel of latency).
module marker_run_detect
  import marker_pkg::*;
#(
  parameter int unsigned X_WIDTH      = 11,
  parameter int unsigned MIN_RUN      = 2,
  parameter int unsigned MAX_RUN      = 64,
  parameter colour_t     COLOUR_OUTER = 3'b100,
  parameter colour_t     COLOUR_INNER = 3'b000
) (
  input logic                clk_in,
  input logic                rst_in,
  marker_run_detect_if.slave bus
);
  typedef struct packed {
    state_t                st;
    logic [EV_X_WIDTH-1:0] o1_start;
    logic [EV_X_WIDTH-1:0] o1_len;
    logic [EV_X_WIDTH-1:0] in_len;
    logic                  hit;
    logic [X_WIDTH-1:0]    hit_x;
    logic [X_WIDTH+1:0]    hit_w;
  } fsm_t;

  run_event_t ev_now, ev_pend;
  logic       line_restart;

  state_t                state_q, state_d;
  logic [EV_X_WIDTH-1:0] o1_start_q, o1_start_d, o1_len_q, o1_len_d, in_len_q, in_len_d;
  logic                  found_q, found_d;
  logic [X_WIDTH-1:0]    mx_q, mx_d;
  logic [X_WIDTH+1:0]    mw_q, mw_d;
  fsm_t                  cur, after_pend, after_now;

  run_tracker #(
    .X_WIDTH (X_WIDTH),
    .MAX_RUN (MAX_RUN)
  ) u_tracker (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .pix_vld      (bus.pixel_valid_in),
    .pix          (bus.pixel_in),
    .line_start   (bus.line_start_in),
    .line_end     (bus.line_end_in),
    .ev_now       (ev_now),
    .ev_pend      (ev_pend),
    .line_restart (line_restart)
  );

  // One FSM step per event; hit_x/hit_w carry the previous report forward when no hit occurs.
  function automatic fsm_t step(input fsm_t c, input run_event_t ev);
    fsm_t n;
    logic ok;
    n     = c;
    n.hit = 1'b0;
    ok    = qual(ev.len, MIN_RUN, MAX_RUN);
    if (ev.valid) begin
      if (c.st == S_OUT1 && ev.colour == COLOUR_INNER && ok) begin
        n.st     = S_INN;
        n.in_len = ev.len;
      end else if (c.st == S_INN && ev.colour == COLOUR_OUTER && ok) begin
        n.hit      = 1'b1;
        n.hit_x    = X_WIDTH'(c.o1_start);
        n.hit_w    = (X_WIDTH+2)'(c.o1_len) + (X_WIDTH+2)'(c.in_len) + (X_WIDTH+2)'(ev.len);
        n.st       = S_OUT1;
        n.o1_start = ev.start;
        n.o1_len   = ev.len;
      end else if (ev.colour == COLOUR_OUTER && ok) begin
        n.st       = S_OUT1;
        n.o1_start = ev.start;
        n.o1_len   = ev.len;
      end else begin
        n.st = S_IDLE;
      end
    end
    return n;
  endfunction

  // The pending event belongs to the previous line, so it is stepped before a line restart.
  always_comb begin
    cur.st       = state_q;
    cur.o1_start = o1_start_q;
    cur.o1_len   = o1_len_q;
    cur.in_len   = in_len_q;
    cur.hit      = 1'b0;
    cur.hit_x    = mx_q;
    cur.hit_w    = mw_q;
    after_pend   = step(cur, ev_pend);
    if (line_restart) after_pend.st = S_IDLE;
    after_now    = step(after_pend, ev_now);
    state_d      = after_now.st;
    o1_start_d   = after_now.o1_start;
    o1_len_d     = after_now.o1_len;
    in_len_d     = after_now.in_len;
    found_d      = after_pend.hit | after_now.hit;
    mx_d         = after_now.hit_x;
    mw_d         = after_now.hit_w;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      o1_start_q <= '0;
      o1_len_q   <= '0;
      in_len_q   <= '0;
      found_q    <= 1'b0;
      mx_q       <= '0;
      mw_q       <= '0;
    end else begin
      state_q    <= state_d;
      o1_start_q <= o1_start_d;
      o1_len_q   <= o1_len_d;
      in_len_q   <= in_len_d;
      found_q    <= found_d;
      mx_q       <= mx_d;
      mw_q       <= mw_d;
    end
  end

  assign bus.marker_found_out = found_q;
  assign bus.marker_x_out     = mx_q;
  assign bus.marker_width_out = mw_q;

endmodule

// File: tb/tb_marker_run_detect.sv
// Directed table-driven bench for marker_run_detect (MIN_RUN=2, MAX_RUN=8, OUTER=100, INNER=000).
module tb_marker_run_detect;
  import marker_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  marker_run_detect_if #(.X_WIDTH(11)) bus();

  marker_run_detect #(
    .X_WIDTH      (11),
    .MIN_RUN      (2),
    .MAX_RUN      (8),
    .COLOUR_OUTER (3'b100),
    .COLOUR_INNER (3'b000)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        vld;
    logic        ls;
    logic        le;
    colour_t     pix;
    logic        f;
    logic [10:0] x;
    logic [12:0] w;
  } vec_t;

  localparam colour_t O = 3'b100;
  localparam colour_t I = 3'b000;
  localparam colour_t B = 3'b001;
  localparam colour_t G = 3'b010;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [10:0] hold_x;
  logic [12:0] hold_w;

  // n pixels of one colour; ls on the first, le and the expected pulse on the last.
  task automatic add(input int n, input colour_t p, input logic ls, input logic le,
                     input logic f, input logic [10:0] x, input logic [12:0] w);
    for (int i = 0; i < n; i++)
      vecs.push_back('{1'b1, ls && (i == 0), le && (i == n - 1), p, f && (i == n - 1), x, w});
  endtask

  task automatic gap(input logic [10:0] x, input logic [12:0] w);
    vecs.push_back('{1'b0, 1'b0, 1'b0, O, 1'b0, x, w});
  endtask

  task automatic drive(input logic v, input logic ls, input logic le, input colour_t p);
    @(negedge clk);
    bus.pixel_valid_in = v;
    bus.line_start_in  = ls;
    bus.line_end_in    = le;
    bus.pixel_in       = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic f, input logic [10:0] x, input logic [12:0] w);
    check({tag, "_found"}, 32'(bus.marker_found_out), 32'(f));
    check({tag, "_x"},     32'(bus.marker_x_out),     32'(x));
    check({tag, "_width"}, 32'(bus.marker_width_out), 32'(w));
  endtask

  initial begin
    bus.pixel_valid_in = 1'b0;
    bus.line_start_in  = 1'b0;
    bus.line_end_in    = 1'b0;
    bus.pixel_in       = '0;

`ifdef GLITCH_FILTER_EN
    // Glitch inside INNER is absorbed; OUTER2 closes one pixel later than unfiltered.
    add(2, B, 1, 0, 0, 0, 0);
    add(3, O, 0, 0, 0, 0, 0);
    add(2, I, 0, 0, 0, 0, 0);
    add(1, G, 0, 0, 0, 0, 0);
    add(3, O, 0, 0, 0, 0, 0);
    add(1, B, 0, 0, 0, 0, 0);
    add(1, B, 0, 1, 1, 2, 9);
`else
    // INNER of one pixel: no marker, outputs stay at reset value.
    add(2, B, 1, 0, 0, 0, 0);
    add(3, O, 0, 0, 0, 0, 0);
    add(1, I, 0, 0, 0, 0, 0);
    add(3, O, 0, 0, 0, 0, 0);
    add(2, B, 0, 1, 0, 0, 0);
    // Basic marker with an idle beat inside INNER.
    add(2, B, 1, 0, 0, 0, 0);
    add(3, O, 0, 0, 0, 0, 0);
    add(2, I, 0, 0, 0, 0, 0);
    gap(0, 0);
    add(1, I, 0, 0, 0, 0, 0);
    add(3, O, 0, 0, 0, 0, 0);
    add(1, B, 0, 0, 1, 2, 9);
    add(1, B, 0, 1, 0, 2, 9);
    // OUTER1 of 9 saturates and fails.
    add(1, B, 1, 0, 0, 2, 9);
    add(9, O, 0, 0, 0, 2, 9);
    add(3, I, 0, 0, 0, 2, 9);
    add(3, O, 0, 0, 0, 2, 9);
    add(1, B, 0, 1, 0, 2, 9);
    // Minimum-length marker, OUTER2 closed by colour change on the line-end pixel.
    add(2, O, 1, 0, 0, 2, 9);
    add(2, I, 0, 0, 0, 2, 9);
    add(2, O, 0, 0, 0, 2, 9);
    add(1, B, 0, 1, 1, 0, 6);
    // OUTER1 exactly MAX_RUN qualifies.
    add(8, O, 1, 0, 0, 0, 6);
    add(2, I, 0, 0, 0, 0, 6);
    add(2, O, 0, 0, 0, 0, 6);
    add(1, B, 0, 1, 1, 0, 12);
    // Overlapping markers; the second closes on line_end.
    add(2, O, 1, 0, 0, 0, 12);
    add(2, I, 0, 0, 0, 0, 12);
    add(2, O, 0, 0, 0, 0, 12);
    add(1, I, 0, 0, 1, 0, 6);
    add(1, I, 0, 0, 0, 0, 6);
    add(1, O, 0, 0, 0, 0, 6);
    add(1, O, 0, 1, 1, 4, 6);
`endif

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 11'd0, 13'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].ls, vecs[i].le, vecs[i].pix);
      check_outs($sformatf("v%0d", i), vecs[i].f, vecs[i].x, vecs[i].w);
    end
    drive(1'b0, 1'b0, 1'b0, I);
    hold_x = vecs[vecs.size() - 1].x;
    hold_w = vecs[vecs.size() - 1].w;
    check_outs("idle", 1'b0, hold_x, hold_w);

    // Reset between INNER and OUTER2 discards the partial marker.
    drive(1'b1, 1'b1, 1'b0, B);
    drive(1'b1, 1'b0, 1'b0, B);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, O);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, I);
    check_outs("pre_rst", 1'b0, hold_x, hold_w);
    @(negedge clk);
    bus.pixel_valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 1'b0, 11'd0, 13'd0);
    @(posedge clk);
    #1;
    check_outs("rst_held", 1'b0, 11'd0, 13'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, O);
      check("post_rst_found", 32'(bus.marker_found_out), 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, B);
    check("post_rst_found", 32'(bus.marker_found_out), 32'd0);
    drive(1'b1, 1'b0, 1'b1, B);
    check_outs("post_rst_end", 1'b0, 11'd0, 13'd0);
    drive(1'b0, 1'b0, 1'b0, I);
    check_outs("post_rst_idle", 1'b0, 11'd0, 13'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
